// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, DEPTH-entry {instr, pc} queue, redirect flush.
// Optional same-cycle bypass of an empty queue under `FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     imem_read,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [31:0] target;
    logic        fifo_valid;
    logic        resp;
    logic        bypass;
    logic        pop;
    logic        pop_fifo;
    logic        push;
    logic [CW:0] occ;
    logic [CW:0] limit;
    logic        can_issue;

    assign target     = {redirect_target[31:2], 2'b00};
    assign fifo_valid = (count != '0);
    assign resp       = inflight & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp & ~fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~redirect & (fifo_valid | bypass);
    assign pop       = out_valid & out_ready;
    assign pop_fifo  = pop & ~bypass;
    assign push      = resp & ~(bypass & pop);

    always_comb begin
        out_instr = 32'h0;
        out_pc    = 32'h0;
        if (out_valid) begin
            if (bypass) begin
                out_instr = imem_data;
                out_pc    = inflight_pc;
            end else begin
                out_instr = instr_mem[rd_ptr];
                out_pc    = pc_mem[rd_ptr];
            end
        end
    end

    // Only fetch when a slot is guaranteed for the response next cycle.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign limit     = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
    assign can_issue = occ < limit;

    assign imem_read = reset_n & (redirect | can_issue);
    assign imem_addr = redirect ? target : pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            pc          <= target + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_read;
            if (imem_read) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: queue-based reference model plus
// a pop-driven scoreboard monitor.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset_n;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_read       (imem_read),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_ready       (out_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h100 + a;
    endfunction

    // Synchronous instruction memory, one-cycle read latency
    logic [31:0] last_addr = 32'h0;
    always @(posedge clock) begin
        if (imem_read) last_addr <= imem_addr;
    end
    assign imem_data = instr_of(last_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of fetched-but-unconsumed
    // entries, the outstanding request, and the next fetch address.
    logic [63:0] sb [$];
    logic        m_inf = 1'b0;
    logic [31:0] m_ipc = 32'h0;
    logic [31:0] m_pc  = RESET_PC;

    task automatic cyc(input logic rst, input logic rdy, input logic rd,
                       input logic [31:0] tgt);
        logic        ev;
        logic        ep;
        logic        ei;
        logic        byp;
        int          cnt;
        logic [31:0] taddr;
        @(negedge clock);
        reset_n         = rst;
        out_ready       = rdy;
        redirect        = rd;
        redirect_target = tgt;
        #1;
        taddr = {tgt[31:2], 2'b00};
        byp   = 1'b0;
        ei    = 1'b0;
        if (!rst) begin
            check("rst_imem_read", 32'(imem_read), 32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_count", 32'(count), 32'h0);
            check("rst_out_instr", out_instr, 32'h0);
            check("rst_out_pc", out_pc, 32'h0);
        end else begin
`ifdef FETCH_BYPASS_EN
            if (!rd && m_inf && sb.size() == 0) begin
                sb.push_back({m_ipc, instr_of(m_ipc)});
                byp = 1'b1;
            end
`endif
            ev  = !rd && sb.size() > 0;
            ep  = ev && rdy;
            cnt = sb.size() - (byp ? 1 : 0);
            ei  = rd || (cnt + int'(m_inf) - int'(ep) < DEPTH);
            check("out_valid", 32'(out_valid), 32'(ev));
            check("count", 32'(count), 32'(cnt));
            check("imem_read", 32'(imem_read), 32'(ei));
            if (ei) check("imem_addr", imem_addr, rd ? taddr : m_pc);
        end
        @(posedge clock);
        if (!rst) begin
            sb.delete();
            m_inf = 1'b0;
            m_pc  = RESET_PC;
        end else if (rd) begin
            sb.delete();
            m_inf = 1'b1;
            m_ipc = taddr;
            m_pc  = taddr + 32'd4;
        end else begin
            if (m_inf && !byp) begin
                if (sb.size() >= DEPTH) begin
                    total++;
                    bad++;
                    $display("FAIL overflow: push with %0d entries", sb.size());
                end
                sb.push_back({m_ipc, instr_of(m_ipc)});
            end
            if (ei) begin
                m_inf = 1'b1;
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end else begin
                m_inf = 1'b0;
            end
        end
    endtask

    // Monitor: every accepted output must match the oldest expected entry
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %h expected none",
                             out_pc);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e[63:32]);
                    check("out_instr", out_instr, e[31:0]);
                end
            end
        end
    end

    initial begin
        reset_n         = 1'b0;
        out_ready       = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;

        repeat (2) cyc(0, 0, 0, 0);
        repeat (20) cyc(1, 1, 0, 0);

        repeat (2) cyc(0, 0, 0, 0);
        repeat (12) cyc(1, 0, 0, 0);
        repeat (8) cyc(1, 1, 0, 0);

        repeat (2) cyc(0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h43);
        repeat (6) cyc(1, 1, 0, 0);

        cyc(1, 1, 1, 32'h200);
        cyc(1, 1, 1, 32'h300);
        repeat (8) cyc(1, 1, 0, 0);

        repeat (10) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);

        cyc(1, 1, 1, 32'hFFFF_FFF8);
        repeat (8) cyc(1, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0,
                $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
